// File: rtl/song_pkg.sv
// Shared constants for the song player display path.
// Glyphs are active-low, bit 0 = segment a, bit 6 = segment g.
package song_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;

  localparam logic [1:0] DIG_LOW  = 2'd0;
  localparam logic [1:0] DIG_MED  = 2'd1;
  localparam logic [1:0] DIG_HIGH = 2'd2;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_ON    = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Note digit to active-low 7-segment glyph.
// 0 is a rest (blank), 1..7 are notes, anything else shows a dash.
module seg7_decode
  import song_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Pure lookup; out-of-range digits fall to the dash glyph
  always_comb begin
    seg_o = SEG_DASH;
    unique case (digit_i)
      4'd0:    seg_o = SEG_BLANK;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/note_display.sv
// Synchronises and debounces the note bus, then scans it onto a
// 3-digit common-anode display with blanking between digits.
module note_display
  import song_pkg::*;
#(
  parameter int SCAN_DIV  = 6000,
  parameter int BLANK_CYC = 60,
  parameter int STABLE    = 4
) (
  input  logic       clk_6MHz,
  input  logic       rst,
  input  logic [3:0] high,
  input  logic [3:0] med,
  input  logic [3:0] low,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       note_chg
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(STABLE + 1);

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE);

  logic [11:0] note_w;
  logic [11:0] meta_q;
  logic [11:0] sync_q;
  logic [11:0] prev_q;
  logic [11:0] acc_q;
  logic [SW-1:0] stab_q, stab_d;
  logic        load_w;
  logic        chg_q;

  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    dig_q, dig_d;
  scan_state_e   state_q, state_d;

  logic [3:0] cur_dig_w;
  logic [6:0] dec_w;
  logic [2:0] an_d, an_q;
  logic [6:0] seg_d, seg_q;

  assign note_w = {high, med, low};

  // Stability counter: counts matching consecutive samples, saturating
  always_comb begin
    stab_d = '0;
    if (sync_q == prev_q) begin
      stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
    end
  end

  assign load_w = (stab_d == STAB_MAX) && (sync_q != acc_q);

  // Two-flop synchroniser, history flop and accepted-note register
  always_ff @(posedge clk_6MHz or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      stab_q <= '0;
      acc_q  <= '0;
      chg_q  <= 1'b0;
    end else begin
      meta_q <= note_w;
      sync_q <= meta_q;
      prev_q <= sync_q;
      stab_q <= stab_d;
      chg_q  <= load_w;
      if (load_w) acc_q <= sync_q;
    end
  end

  // Scan state register with slot counter and digit index
  always_ff @(posedge clk_6MHz or negedge rst) begin
    if (!rst) begin
      state_q    <= SCAN_BLANK;
      scan_cnt_q <= '0;
      dig_q      <= DIG_LOW;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      dig_q      <= dig_d;
    end
  end

  // Next scan position; state tracks whether the slot is past blanking
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    dig_d      = dig_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      dig_d      = (dig_q == DIG_HIGH) ? DIG_LOW : dig_q + 2'd1;
    end
    state_d = (scan_cnt_d < BLANK_END) ? SCAN_BLANK : SCAN_ON;
  end

  // Pick the accepted digit currently being scanned
  always_comb begin
    cur_dig_w = 4'd0;
    unique case (dig_q)
      DIG_LOW:  cur_dig_w = acc_q[3:0];
      DIG_MED:  cur_dig_w = acc_q[7:4];
      DIG_HIGH: cur_dig_w = acc_q[11:8];
      default:  cur_dig_w = 4'd0;
    endcase
  end

  seg7_decode u_dec (
    .digit_i (cur_dig_w),
    .seg_o   (dec_w)
  );

  // Output decode: all dark while blanking, one anode low when on
  always_comb begin
    an_d  = 3'b111;
    seg_d = SEG_BLANK;
    if (state_q == SCAN_ON) begin
      an_d  = ~(3'b001 << dig_q);
      seg_d = dec_w;
    end
  end

  // Registered drive of the display pins
  always_ff @(posedge clk_6MHz or negedge rst) begin
    if (!rst) begin
      an_q  <= 3'b111;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign note_chg = chg_q;

endmodule

// File: tb/tb_note_display.sv
// Self-checking bench for note_display with a short scan slot.
// Reference model works from sample history and scan position.
module tb_note_display;

  localparam int SD = 20;
  localparam int BC = 4;
  localparam int ST = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] in_v = 12'h000;
  logic [2:0]  an;
  logic [6:0]  seg;
  logic        note_chg;

  always #5 clk = ~clk;

  note_display #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC),
    .STABLE    (ST)
  ) dut (
    .clk_6MHz (clk),
    .rst      (rst),
    .high     (in_v[11:8]),
    .med      (in_v[7:4]),
    .low      (in_v[3:0]),
    .an       (an),
    .seg      (seg),
    .note_chg (note_chg)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0]  glyph [16];
  logic [11:0] hist [ST+3];
  logic [11:0] macc;
  int          cyc;
  logic [2:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_chg;

  task automatic model_reset();
    cyc = 0;
    macc = 12'h000;
    for (int i = 0; i < ST + 3; i++) hist[i] = 12'h000;
    e_an = 3'b111;
    e_seg = 7'h7F;
    e_chg = 1'b0;
  endtask

  // One clock: model sees the input at the edge, outputs read at negedge
  task automatic step();
    int p;
    int d;
    bit stable;
    @(posedge clk);
    if (rst) begin
      for (int i = ST + 2; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = in_v;
      cyc++;
      p = (cyc - 1) % (3 * SD);
      d = p / SD;
      if ((p % SD) < BC) begin
        e_an = 3'b111;
        e_seg = 7'h7F;
      end else begin
        e_an = ~(3'b001 << d);
        e_seg = glyph[macc[4*d +: 4]];
      end
      stable = 1'b1;
      for (int i = 3; i <= ST + 2; i++)
        if (hist[i] != hist[2]) stable = 1'b0;
      e_chg = 1'b0;
      if (stable && hist[2] != macc) begin
        macc = hist[2];
        e_chg = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_v = 12'h003;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      tests++;
      if ({an, seg, note_chg} !== {3'b111, 7'h7F, 1'b0}) begin
        fails++;
        $display("FAIL reset k=%0d got an=%b seg=%h chg=%b want 111/7f/0",
                 k, an, seg, note_chg);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_accept();
    int first = -1;
    int pulses = 0;
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      tests++;
      if ({an, seg, note_chg} !== {e_an, e_seg, e_chg}) begin
        fails++;
        $display("FAIL accept cyc=%0d got %b/%h/%b want %b/%h/%b",
                 cyc, an, seg, note_chg, e_an, e_seg, e_chg);
      end
      if (note_chg) begin
        pulses++;
        if (first < 0) first = cyc;
      end
    end
    tests++;
    if (pulses != 1 || first != 7) begin
      fails++;
      $display("FAIL accept_pulse got n=%0d at=%0d want n=1 at=7", pulses, first);
    end
    for (int k = 0; k < 80 && !seen; k++) begin
      step();
      if (an === 3'b110) seen = 1'b1;
    end
    tests++;
    if (!seen || seg !== 7'h30) begin
      fails++;
      $display("FAIL accept_dig0 seen=%0b got seg=%h want 30", seen, seg);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    bit seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      in_v = ((k / 2) % 2 == 1) ? 12'h006 : 12'h005;
      step();
      tests++;
      if ({an, seg, note_chg} !== {e_an, e_seg, e_chg}) begin
        fails++;
        $display("FAIL glitch cyc=%0d got %b/%h/%b want %b/%h/%b",
                 cyc, an, seg, note_chg, e_an, e_seg, e_chg);
      end
      if (note_chg) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL glitch_pulse got %0d want 0", pulses);
    end
    in_v = 12'h006;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (note_chg) pulses++;
    end
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL hold_pulse got %0d want 1", pulses);
    end
    for (int k = 0; k < 80 && !seen; k++) begin
      step();
      if (an === 3'b110) seen = 1'b1;
    end
    tests++;
    if (!seen || seg !== 7'h02) begin
      fails++;
      $display("FAIL hold_dig0 seen=%0b got seg=%h want 02", seen, seg);
    end
  endtask

  task automatic test_scan();
    logic [2:0] last = an;
    logic [2:0] nxt;
    bit found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      last = an;
      step();
      if (an === 3'b111 && last !== 3'b111) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL scan_boundary got none want blank after on");
    end
    nxt = (last == 3'b110) ? 3'b101 : (last == 3'b101) ? 3'b011 : 3'b110;
    for (int pos = 1; pos < 4 * SD; pos++) begin
      if (pos % SD == 0)
        nxt = (nxt == 3'b110) ? 3'b101 : (nxt == 3'b101) ? 3'b011 : 3'b110;
      step();
      tests++;
      if (an !== (((pos % SD) < BC) ? 3'b111 : nxt)) begin
        fails++;
        $display("FAIL scan pos=%0d got an=%b want %b", pos, an,
                 ((pos % SD) < BC) ? 3'b111 : nxt);
      end
    end
  endtask

  task automatic test_decode();
    int pulses = 0;
    int hits = 0;
    in_v = 12'h100;
    for (int k = 0; k < 30; k++) step();
    for (int k = 0; k < 3 * SD; k++) begin
      step();
      tests++;
      if ((an === 3'b011 && seg !== 7'h79) ||
          ((an === 3'b110 || an === 3'b101) && seg !== 7'h7F)) begin
        fails++;
        $display("FAIL dec_100 an=%b got seg=%h", an, seg);
      end
      if (an === 3'b011) hits++;
    end
    in_v = 12'h0F0;
    for (int k = 0; k < 30; k++) step();
    for (int k = 0; k < 3 * SD; k++) begin
      step();
      tests++;
      if ((an === 3'b101 && seg !== 7'h3F) ||
          ((an === 3'b110 || an === 3'b011) && seg !== 7'h7F)) begin
        fails++;
        $display("FAIL dec_0f0 an=%b got seg=%h", an, seg);
      end
      if (an === 3'b101) hits++;
    end
    tests++;
    if (hits != 2 * (SD - BC)) begin
      fails++;
      $display("FAIL dec_hits got %0d want %0d", hits, 2 * (SD - BC));
    end
    in_v = 12'h0F1;
    step();
    in_v = 12'h0F0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (note_chg) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL no_repeat got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int k = 0; k < 600; k++) begin
      if (hold == 0) begin
        in_v = 12'($urandom_range(0, 4095));
        if ($urandom_range(0, 1) == 1) in_v = in_v & 12'h777;
        hold = $urandom_range(1, 9);
      end
      hold--;
      step();
      tests++;
      if ({an, seg, note_chg} !== {e_an, e_seg, e_chg}) begin
        fails++;
        $display("FAIL random cyc=%0d in=%h got %b/%h/%b want %b/%h/%b",
                 cyc, in_v, an, seg, note_chg, e_an, e_seg, e_chg);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    in_v = 12'h003;
    for (int k = 0; k < 30; k++) step();
    for (int k = 0; k < 80 && !seen; k++) begin
      step();
      if (an === 3'b101) seen = 1'b1;
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (!seen || {an, seg, note_chg} !== {3'b111, 7'h7F, 1'b0}) begin
      fails++;
      $display("FAIL rst_async seen=%0b got %b/%h/%b want 111/7f/0",
               seen, an, seg, note_chg);
    end
    model_reset();
    step();
    rst = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      tests++;
      if ({an, seg, note_chg} !== {e_an, e_seg, e_chg}) begin
        fails++;
        $display("FAIL rst_mid cyc=%0d got %b/%h/%b want %b/%h/%b",
                 cyc, an, seg, note_chg, e_an, e_seg, e_chg);
      end
      if (k == 5) begin
        tests++;
        if (an !== 3'b110 || seg !== 7'h7F) begin
          fails++;
          $display("FAIL rst_acc0 got an=%b seg=%h want 110/7f", an, seg);
        end
      end
    end
  endtask

  initial begin
    glyph[0] = 7'h7F;
    glyph[1] = 7'h79;
    glyph[2] = 7'h24;
    glyph[3] = 7'h30;
    glyph[4] = 7'h19;
    glyph[5] = 7'h12;
    glyph[6] = 7'h02;
    glyph[7] = 7'h78;
    for (int i = 8; i < 16; i++) glyph[i] = 7'h3F;
    model_reset();
    @(negedge clk);
    test_reset();
    test_accept();
    test_glitch();
    test_scan();
    test_decode();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
